rom_arbiter: RTL

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter_pkg.sv | 9 +
 rtl/rom_arbiter_rr_arb2.sv | 11 +
 rtl/rom_arbiter.sv | 65 ++++++
 3 files changed

// File: rtl/rom_arbiter_pkg.sv
// rom_arbiter_pkg: shared parameter defaults and FSM state encoding for rom_arbiter
package rom_arbiter_pkg;
  localparam int DEPTH_DEF  = 10;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 10;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
endpackage

// File: rtl/rom_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick; on a tie the requester that did not win last time wins
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic winner,
  output logic any
);
  assign winner = (req0 && req1) ? ~last_owner : req1;
  assign any    = req0 | req1;
endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one combinational ROM between two requesters, one read in flight at a time
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);
  logic [1:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic              owner_q;
  logic              last_owner;
  logic              win;
  logic              any;
  logic              oor;
  rr_arb2 u_arb (
    .req0       (req0),
    .req1       (req1),
    .last_owner (last_owner),
    .winner     (win),
    .any        (any)
  );
  assign oor      = 32'(addr_q) >= 32'(DEPTH);
  assign rom_addr = addr_q;
  assign gnt0     = state == READ && !owner_q;
  assign gnt1     = state == READ && owner_q;
  assign rvalid0  = state == RESP && !owner_q;
  assign rvalid1  = state == RESP && owner_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      owner_q    <= 1'b0;
      last_owner <= 1'b1;
      rdata      <= '0;
      err        <= 1'b0;
    end else begin
      state <= state == IDLE ? (any ? READ : IDLE) : state == READ ? RESP : IDLE;
      if (state == IDLE && any) begin
        addr_q     <= win ? addr1 : addr0;
        owner_q    <= win;
        last_owner <= win;
      end
      if (state == READ) begin
        rdata <= oor ? '0 : rom_data;
        err   <= oor;
      end
    end
  end
endmodule
